// File: rtl/matc_row_reorder_if.sv
// ---------------------------------------------------------------------------
// matc_row_reorder_if
// Stream bundle between the systolic matmul result path, the row reorder
// stage and its downstream consumer.
//
// Signals:
//   in_valid       result block present (from accumulator-done)
//   in_ready       reorder stage can take a block
//   in_data        one BLOCK_SIZE x BLOCK_SIZE block, element (r,c) at
//                  [(r*BLOCK_SIZE+c)*WIDTH +: WIDTH]
//   out_valid      out_data carries a valid row slice
//   out_ready      consumer accepts the current slice
//   out_data       one block-row slice, element c at [c*WIDTH +: WIDTH]
//   out_row_last   slice is the last one of a C row
//   out_frame_last slice is the last one of matrix C
//
// Modports:
//   slave  - the reorder stage itself
//   master - the environment around it (producer + consumer)
// ---------------------------------------------------------------------------
interface matc_row_reorder_if #(
    parameter int WIDTH      = 16,
    parameter int BLOCK_SIZE = 2,
    parameter int CHUNK_SIZE = 4
);
    logic                          in_valid;
    logic                          in_ready;
    logic [WIDTH*CHUNK_SIZE-1:0]   in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [WIDTH*BLOCK_SIZE-1:0]   out_data;
    logic                          out_row_last;
    logic                          out_frame_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_row_last, out_frame_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_row_last, out_frame_last
    );
endinterface

// File: rtl/matc_row_reorder.sv
// ---------------------------------------------------------------------------
// matc_row_reorder
// Output reorder stage behind the systolic matmul. Whole result blocks of C
// arrive one per beat and are collected into a ping-pong buffer that holds
// one block-row of C per bank. A full bank is re-emitted as row-major slices
// (row r of every block in the block-row, then row r+1, ...) so downstream
// logic sees complete C rows in order.
//
// Ports:
//   clk      single clock
//   rst_n    asynchronous active-low reset
//   i_flush  synchronous abort, clears pointers and flags, beats ignored
//   bus      matc_row_reorder_if.slave (input block stream, output slices)
//   o_done   one-cycle pulse after the out_frame_last beat is accepted
//
// Optional build macro MATC_REORDER_STATS_EN adds:
//   o_ovf_sticky  set once any block is dropped (in_valid while !in_ready)
//   o_drop_cnt    saturating count of dropped blocks
// ---------------------------------------------------------------------------
module matc_row_reorder #(
    parameter int WIDTH             = 16,
    parameter int BLOCK_SIZE        = 2,
    parameter int CHUNK_SIZE        = 4,
    parameter int W_OUTER_DIMENSION = 6,
    parameter int I_OUTER_DIMENSION = 6,
    parameter int COL_SIZE_MAT_C    = W_OUTER_DIMENSION / BLOCK_SIZE,
    parameter int ROW_SIZE_MAT_C    = I_OUTER_DIMENSION / BLOCK_SIZE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_flush,
    matc_row_reorder_if.slave       bus,
    output logic                    o_done
`ifdef MATC_REORDER_STATS_EN
   ,output logic                    o_ovf_sticky,
    output logic [15:0]             o_drop_cnt
`endif
);

    localparam int BLK_W   = (COL_SIZE_MAT_C > 1) ? $clog2(COL_SIZE_MAT_C) : 1;
    localparam int ROW_W   = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int BROW_W  = (ROW_SIZE_MAT_C > 1) ? $clog2(ROW_SIZE_MAT_C) : 1;
    localparam int WORD_W  = WIDTH * CHUNK_SIZE;
    localparam int SLICE_W = WIDTH * BLOCK_SIZE;

    localparam logic [BLK_W-1:0]  LAST_BLK  = BLK_W'(COL_SIZE_MAT_C - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(BLOCK_SIZE - 1);
    localparam logic [BROW_W-1:0] LAST_BROW = BROW_W'(ROW_SIZE_MAT_C - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    logic [WORD_W-1:0] r_buf [0:1][0:COL_SIZE_MAT_C-1];

    logic              r_wr_bank;
    logic [BLK_W-1:0]  r_wr_blk;
    logic [1:0]        r_bank_full;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_rd_bank;
    logic [ROW_W-1:0]  r_rd_row;
    logic [BLK_W-1:0]  r_rd_blk;
    logic [BROW_W-1:0] r_blkrow_cnt;
    logic              r_done;

    logic              w_in_ready;
    logic              w_wr_fire;
    logic              w_wr_last;
    logic              w_out_valid;
    logic              w_rd_fire;
    logic              w_rd_bank_last;
    logic              w_rd_free;
    logic              w_frame_last;
    logic [1:0]        w_full_nxt;
    logic              w_rd_bank_nxt;
    logic [WORD_W-1:0] w_rd_word;

    assign w_in_ready     = !r_bank_full[r_wr_bank];
    assign w_wr_fire      = bus.in_valid && w_in_ready && !i_flush;
    assign w_wr_last      = (r_wr_blk == LAST_BLK);

    assign w_out_valid    = (r_state == S_STREAM);
    assign w_rd_fire      = w_out_valid && bus.out_ready && !i_flush;
    assign w_rd_bank_last = (r_rd_row == LAST_ROW) && (r_rd_blk == LAST_BLK);
    assign w_rd_free      = w_rd_fire && w_rd_bank_last;
    assign w_frame_last   = w_rd_bank_last && (r_blkrow_cnt == LAST_BROW);

    // Bank-full flags as they will be after this edge. Completing a write
    // and freeing a read bank in the same cycle always touch different banks,
    // because the write bank was not full (in_ready high) while the read bank
    // was.
    always_comb begin
        w_full_nxt    = r_bank_full;
        w_rd_bank_nxt = r_rd_bank;
        if (w_wr_fire && w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_free) begin
            w_full_nxt[r_rd_bank] = 1'b0;
            w_rd_bank_nxt         = ~r_rd_bank;
        end
    end

    // Looking at next-cycle flags lets out_valid rise on the cycle right
    // after the bank-completing write, and lets the reader move straight onto
    // the other bank without a bubble when it is already full.
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_full_nxt[w_rd_bank_nxt]) begin
                        w_state_nxt = S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_rd_free) begin
                        w_state_nxt = w_full_nxt[w_rd_bank_nxt] ? S_STREAM : S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank   <= 1'b0;
            r_wr_blk    <= '0;
            r_bank_full <= 2'b00;
        end else if (i_flush) begin
            r_wr_bank   <= 1'b0;
            r_wr_blk    <= '0;
            r_bank_full <= 2'b00;
        end else begin
            r_bank_full <= w_full_nxt;
            if (w_wr_fire) begin
                if (w_wr_last) begin
                    r_wr_blk  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_blk  <= r_wr_blk + 1'b1;
                end
            end
        end
    end

    // Buffer storage needs no reset; a bank is only read once its full flag
    // says every slot was written since the last reset/flush.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_buf[r_wr_bank][r_wr_blk] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_bank    <= 1'b0;
            r_rd_row     <= '0;
            r_rd_blk     <= '0;
            r_blkrow_cnt <= '0;
            r_done       <= 1'b0;
        end else if (i_flush) begin
            r_rd_bank    <= 1'b0;
            r_rd_row     <= '0;
            r_rd_blk     <= '0;
            r_blkrow_cnt <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_rd_fire && w_frame_last;
            if (w_rd_fire) begin
                if (r_rd_blk == LAST_BLK) begin
                    r_rd_blk <= '0;
                    if (r_rd_row == LAST_ROW) begin
                        r_rd_row  <= '0;
                        r_rd_bank <= ~r_rd_bank;
                        if (r_blkrow_cnt == LAST_BROW) begin
                            r_blkrow_cnt <= '0;
                        end else begin
                            r_blkrow_cnt <= r_blkrow_cnt + 1'b1;
                        end
                    end else begin
                        r_rd_row <= r_rd_row + 1'b1;
                    end
                end else begin
                    r_rd_blk <= r_rd_blk + 1'b1;
                end
            end
        end
    end

    // Slice r of the current block: the r-th group of BLOCK_SIZE elements.
    assign w_rd_word = r_buf[r_rd_bank][r_rd_blk];

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = w_out_valid;
    assign bus.out_data       = w_rd_word[int'(r_rd_row) * SLICE_W +: SLICE_W];
    assign bus.out_row_last   = w_out_valid && (r_rd_blk == LAST_BLK);
    assign bus.out_frame_last = w_out_valid && w_frame_last;
    assign o_done             = r_done;

`ifdef MATC_REORDER_STATS_EN
    logic        w_drop;
    logic        r_ovf_sticky;
    logic [15:0] r_drop_cnt;

    assign w_drop = bus.in_valid && !w_in_ready && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
            r_drop_cnt   <= '0;
        end else if (i_flush) begin
            r_ovf_sticky <= 1'b0;
            r_drop_cnt   <= '0;
        end else if (w_drop) begin
            r_ovf_sticky <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign o_ovf_sticky = r_ovf_sticky;
    assign o_drop_cnt   = r_drop_cnt;
`endif

endmodule

// File: tb/tb_matc_row_reorder.sv
// ---------------------------------------------------------------------------
// tb_matc_row_reorder
// Self-checking bench for matc_row_reorder with default parameters
// (2x2 blocks, 6x6 matrix C: 3 blocks per block-row, 3 block-rows).
// Inputs change 2 ns after the rising edge; outputs are sampled on the
// falling edge or 2 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_matc_row_reorder;

    localparam int WIDTH  = 16;
    localparam int BS     = 2;
    localparam int CS     = 4;
    localparam int FRAME  = 18;

    typedef struct {
        logic [63:0] blkIn;
        logic [31:0] expData;
        logic        expRowLast;
        logic        expFrameLast;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        rowLast;
        logic        frameLast;
        int          cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic done;
`ifdef MATC_REORDER_STATS_EN
    logic        ovfSticky;
    logic [15:0] dropCnt;
`endif

    int total = 0;
    int bad = 0;
    int cycleCnt = 0;
    int doneCount = 0;
    beat_t beatQ[$];
    vec_t frameTbl[FRAME];

    logic        prevStall = 1'b0;
    logic [31:0] prevData = '0;
    logic        prevFrameAcc = 1'b0;

    matc_row_reorder_if #(.WIDTH(WIDTH), .BLOCK_SIZE(BS), .CHUNK_SIZE(CS)) bus();

    matc_row_reorder #(
        .WIDTH(WIDTH), .BLOCK_SIZE(BS), .CHUNK_SIZE(CS),
        .W_OUTER_DIMENSION(6), .I_OUTER_DIMENSION(6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (flush),
        .bus          (bus),
        .o_done       (done)
`ifdef MATC_REORDER_STATS_EN
       ,.o_ovf_sticky (ovfSticky),
        .o_drop_cnt   (dropCnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: records accepted beats, checks hold-while-stalled and
    // that done follows the frame_last acceptance by exactly one cycle.
    always @(negedge clk) begin
        beat_t b;
        if (!rst_n || flush) begin
            prevStall    = 1'b0;
            prevFrameAcc = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("hold_valid", 64'(bus.out_valid), 64'd1);
                checkOutput("hold_data", 64'(bus.out_data), 64'(prevData));
            end
            if (done) begin
                doneCount++;
                checkOutput("done_timing", 64'(prevFrameAcc), 64'd1);
            end
            prevFrameAcc = bus.out_valid && bus.out_ready && bus.out_frame_last;
            if (bus.out_valid && bus.out_ready) begin
                b.data      = bus.out_data;
                b.rowLast   = bus.out_row_last;
                b.frameLast = bus.out_frame_last;
                b.cyc       = cycleCnt;
                beatQ.push_back(b);
            end
            prevStall = bus.out_valid && !bus.out_ready;
            prevData  = bus.out_data;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    // Waits (bounded) for in_ready, then presents one block for one cycle.
    task automatic applyStimulus(input logic [63:0] blk);
        int guard = 0;
        while (!bus.in_ready && guard < 200) begin
            stepCycle();
            guard++;
        end
        checkOutput("in_ready_wait", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = blk;
        stepCycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic doReset();
        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) stepCycle();
        rst_n = 1'b1;
        stepCycle();
    endtask

    task automatic waitBeats(input int base, input int n);
        int guard = 0;
        while (beatQ.size() < base + n && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        #2;
        checkOutput("beat_count", 64'(beatQ.size() - base), 64'(n));
    endtask

    task automatic checkFrame(input string tag, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if (base + i < beatQ.size()) begin
                checkOutput({tag, "_data"}, 64'(beatQ[base+i].data), 64'(frameTbl[i % FRAME].expData));
                checkOutput({tag, "_rowlast"}, 64'(beatQ[base+i].rowLast), 64'(frameTbl[i % FRAME].expRowLast));
                checkOutput({tag, "_framelast"}, 64'(beatQ[base+i].frameLast), 64'(frameTbl[i % FRAME].expFrameLast));
            end
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({tag, "_row_last"}, 64'(bus.out_row_last), 64'd0);
        checkOutput({tag, "_frame_last"}, 64'(bus.out_frame_last), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
`ifdef MATC_REORDER_STATS_EN
        checkOutput({tag, "_drop_cnt"}, 64'(dropCnt), 64'd0);
        checkOutput({tag, "_ovf"}, 64'(ovfSticky), 64'd0);
`endif
    endtask

    task automatic writeFrame();
        for (int k = 0; k < 9; k++) applyStimulus(frameTbl[k].blkIn);
    endtask

    initial begin
        int base;
        int doneBase;

        // Block k holds 4k+1..4k+4; beats listed in expected emission order.
        frameTbl[0]  = '{64'h0004_0003_0002_0001, 32'h0002_0001, 1'b0, 1'b0};
        frameTbl[1]  = '{64'h0008_0007_0006_0005, 32'h0006_0005, 1'b0, 1'b0};
        frameTbl[2]  = '{64'h000C_000B_000A_0009, 32'h000A_0009, 1'b1, 1'b0};
        frameTbl[3]  = '{64'h0010_000F_000E_000D, 32'h0004_0003, 1'b0, 1'b0};
        frameTbl[4]  = '{64'h0014_0013_0012_0011, 32'h0008_0007, 1'b0, 1'b0};
        frameTbl[5]  = '{64'h0018_0017_0016_0015, 32'h000C_000B, 1'b1, 1'b0};
        frameTbl[6]  = '{64'h001C_001B_001A_0019, 32'h000E_000D, 1'b0, 1'b0};
        frameTbl[7]  = '{64'h0020_001F_001E_001D, 32'h0012_0011, 1'b0, 1'b0};
        frameTbl[8]  = '{64'h0024_0023_0022_0021, 32'h0016_0015, 1'b1, 1'b0};
        frameTbl[9]  = '{64'h0,                   32'h0010_000F, 1'b0, 1'b0};
        frameTbl[10] = '{64'h0,                   32'h0014_0013, 1'b0, 1'b0};
        frameTbl[11] = '{64'h0,                   32'h0018_0017, 1'b1, 1'b0};
        frameTbl[12] = '{64'h0,                   32'h001A_0019, 1'b0, 1'b0};
        frameTbl[13] = '{64'h0,                   32'h001E_001D, 1'b0, 1'b0};
        frameTbl[14] = '{64'h0,                   32'h0022_0021, 1'b1, 1'b0};
        frameTbl[15] = '{64'h0,                   32'h001C_001B, 1'b0, 1'b0};
        frameTbl[16] = '{64'h0,                   32'h0020_001F, 1'b0, 1'b0};
        frameTbl[17] = '{64'h0,                   32'h0024_0023, 1'b1, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        doReset();
        checkIdleOutputs("reset");

        // Three blocks -> one block-row, first out_valid one cycle after 3rd write
        base = beatQ.size();
        applyStimulus(frameTbl[0].blkIn);
        applyStimulus(frameTbl[1].blkIn);
        checkOutput("t1_valid_before", 64'(bus.out_valid), 64'd0);
        applyStimulus(frameTbl[2].blkIn);
        checkOutput("t1_valid_latency", 64'(bus.out_valid), 64'd1);
        waitBeats(base, 6);
        checkFrame("t1", base, 6);

        // Full 9-block frame, done pulses once
        doReset();
        base = beatQ.size();
        doneBase = doneCount;
        writeFrame();
        waitBeats(base, FRAME);
        checkFrame("t2", base, FRAME);
        repeat (3) stepCycle();
        checkOutput("t2_done_count", 64'(doneCount - doneBase), 64'd1);

        // Back-pressure: both banks fill, 7th block dropped
        doReset();
        base = beatQ.size();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) applyStimulus(frameTbl[k].blkIn);
        checkOutput("t3_in_ready_low", 64'(bus.in_ready), 64'd0);
        checkOutput("t3_valid_held", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = frameTbl[6].blkIn;
        stepCycle();
        bus.in_valid = 1'b0;
`ifdef MATC_REORDER_STATS_EN
        checkOutput("t3_drop_cnt", 64'(dropCnt), 64'd1);
        checkOutput("t3_ovf", 64'(ovfSticky), 64'd1);
`endif
        repeat (3) stepCycle();
        bus.out_ready = 1'b1;
        waitBeats(base, 12);
        checkFrame("t3", base, 12);
        repeat (3) stepCycle();
        checkOutput("t3_no_extra", 64'(bus.out_valid), 64'd0);
        checkOutput("t3_ready_again", 64'(bus.in_ready), 64'd1);

        // Random out_ready toggling during one frame
        doReset();
        base = beatQ.size();
        doneBase = doneCount;
        fork
            writeFrame();
            begin
                repeat (150) begin
                    @(posedge clk);
                    #2;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        waitBeats(base, FRAME);
        checkFrame("t4", base, FRAME);
        checkOutput("t4_done_count", 64'(doneCount - doneBase), 64'd1);

        // Asynchronous reset mid-frame, then a clean frame
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(frameTbl[k].blkIn);
        checkOutput("t5_pre_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("t5_rst_ready", 64'(bus.in_ready), 64'd1);
        doReset();
        checkIdleOutputs("t5_after_rst");
        base = beatQ.size();
        doneBase = doneCount;
        writeFrame();
        waitBeats(base, FRAME);
        checkFrame("t5", base, FRAME);
        repeat (3) stepCycle();
        checkOutput("t5_done_count", 64'(doneCount - doneBase), 64'd1);

        // Same again with flush
        for (int k = 0; k < 4; k++) applyStimulus(frameTbl[k].blkIn);
        checkOutput("t5f_pre_valid", 64'(bus.out_valid), 64'd1);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = frameTbl[8].blkIn;
        stepCycle();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        checkIdleOutputs("t5f_after_flush");
        base = beatQ.size();
        doneBase = doneCount;
        writeFrame();
        waitBeats(base, FRAME);
        checkFrame("t5f", base, FRAME);
        repeat (3) stepCycle();
        checkOutput("t5f_done_count", 64'(doneCount - doneBase), 64'd1);

        // Two back-to-back frames: no bubble, counter wraps, two done pulses
        doReset();
        base = beatQ.size();
        doneBase = doneCount;
        for (int k = 0; k < 18; k++) applyStimulus(frameTbl[k % 9].blkIn);
        waitBeats(base, 2 * FRAME);
        checkFrame("t6", base, 2 * FRAME);
        if (beatQ.size() >= base + 2 * FRAME) begin
            checkOutput("t6_no_bubble", 64'(beatQ[base + 2*FRAME - 1].cyc - beatQ[base].cyc), 64'(2 * FRAME - 1));
        end
        repeat (3) stepCycle();
        checkOutput("t6_done_count", 64'(doneCount - doneBase), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
